// File: rtl/led_pattern_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : led_pattern_ctrl
// Brief    : Timed pattern sequencer for an 8-LED bank. Supports rotate right,
//            rotate left, bounce and blink, with rate select, pause and
//            single-step while paused.
// Revision : 1.0 - initial release
// ============================================================================
module led_pattern_ctrl #(
    parameter int TICK_COUNT = 2000000   // clock cycles per step at speed 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode,
    input  logic [1:0] speed,
    input  logic       mode_load,
    input  logic       pause,
    input  logic       step,
    output logic [7:0] dataOut,
    output logic       tick,
    output logic       paused
);

    // FSM encoding
    localparam logic [0:0] c_ST_RUN   = 1'b0;
    localparam logic [0:0] c_ST_PAUSE = 1'b1;

    // Bounce direction encoding
    localparam logic c_DIR_RIGHT = 1'b0;
    localparam logic c_DIR_LEFT  = 1'b1;

    // Pattern encoding
    localparam logic [1:0] c_MODE_ROR    = 2'b00;
    localparam logic [1:0] c_MODE_ROL    = 2'b01;
    localparam logic [1:0] c_MODE_BOUNCE = 2'b10;
    localparam logic [1:0] c_MODE_BLINK  = 2'b11;

    // Step period at speed 0, sized to the 22-bit step counter
    localparam logic [21:0] c_TICK = 22'(TICK_COUNT);

    logic [0:0]  r_state;
    logic [1:0]  r_mode;
    logic [1:0]  r_speed;
    logic        r_dir;
    logic [21:0] r_cnt;
    logic [7:0]  r_data;
    logic        r_tick;

    logic [21:0] w_period;
    logic [21:0] w_last;
    logic        w_expire;
    logic        w_advance;
    logic [7:0]  w_seed;
    logic [7:0]  w_adv_data;
    logic        w_adv_dir;

    // Period and end-of-period detection for the currently latched speed
    always_comb begin
        w_period = c_TICK >> r_speed;
        w_last   = w_period - 22'd1;
        w_expire = (r_cnt == w_last);
    end

    // An advance happens on timer expiry while running, or on a step pulse
    // while staying paused; a pause transition on the same edge suppresses it
    always_comb begin
        w_advance = 1'b0;
        if (r_state == c_ST_RUN) begin
            w_advance = !pause && w_expire;
        end else begin
            w_advance = pause && step;
        end
    end

    // Seed value loaded when a new pattern is selected
    always_comb begin
        w_seed = 8'h80;
        case (mode)
            c_MODE_ROR:    w_seed = 8'h80;
            c_MODE_ROL:    w_seed = 8'h01;
            c_MODE_BOUNCE: w_seed = 8'h80;
            c_MODE_BLINK:  w_seed = 8'hFF;
            default:       w_seed = 8'h80;
        endcase
    end

    // Next LED value and bounce direction for one pattern step
    always_comb begin
        w_adv_data = r_data;
        w_adv_dir  = r_dir;
        case (r_mode)
            c_MODE_ROR: w_adv_data = {r_data[0], r_data[7:1]};
            c_MODE_ROL: w_adv_data = {r_data[6:0], r_data[7]};
            c_MODE_BOUNCE: begin
                // Turn around at the end LED without showing it twice
                if (r_dir == c_DIR_RIGHT) begin
                    if (r_data == 8'h01) begin
                        w_adv_dir  = c_DIR_LEFT;
                        w_adv_data = 8'h02;
                    end else begin
                        w_adv_data = {1'b0, r_data[7:1]};
                    end
                end else begin
                    if (r_data == 8'h80) begin
                        w_adv_dir  = c_DIR_RIGHT;
                        w_adv_data = 8'h40;
                    end else begin
                        w_adv_data = {r_data[6:0], 1'b0};
                    end
                end
            end
            c_MODE_BLINK: w_adv_data = ~r_data;
            default:      w_adv_data = r_data;
        endcase
    end

    // Sequencer state: mode load beats pause transitions, which beat advances
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_RUN;
            r_mode  <= c_MODE_ROR;
            r_speed <= 2'b00;
            r_dir   <= c_DIR_RIGHT;
            r_cnt   <= 22'd0;
            r_data  <= 8'h80;
            r_tick  <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (mode_load) begin
                r_mode  <= mode;
                r_speed <= speed;
                r_data  <= w_seed;
                r_cnt   <= 22'd0;
                r_dir   <= c_DIR_RIGHT;
            end else begin
                if (w_advance) begin
                    r_data <= w_adv_data;
                    r_dir  <= w_adv_dir;
                    r_tick <= 1'b1;
                end
                case (r_state)
                    c_ST_RUN: begin
                        if (pause) begin
                            r_state <= c_ST_PAUSE;
                            r_cnt   <= 22'd0;
                        end else if (w_expire) begin
                            r_cnt <= 22'd0;
                        end else begin
                            r_cnt <= r_cnt + 22'd1;
                        end
                    end
                    c_ST_PAUSE: begin
                        // Counter parked at 0 so release gives a full period
                        r_cnt <= 22'd0;
                        if (!pause) begin
                            r_state <= c_ST_RUN;
                        end
                    end
                    default: begin
                        r_state <= c_ST_RUN;
                        r_cnt   <= 22'd0;
                    end
                endcase
            end
        end
    end

    assign dataOut = r_data;
    assign tick    = r_tick;
    assign paused  = (r_state == c_ST_PAUSE);

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_pattern_ctrl
// Brief    : Self-checking bench for led_pattern_ctrl with TICK_COUNT=8.
//            Expected LED values are queued when stimulus is applied and
//            popped when the DUT pulses tick.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_pattern_ctrl;

    localparam int c_TICK = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic [1:0] speed;
    logic       mode_load;
    logic       pause;
    logic       step;
    logic [7:0] dataOut;
    logic       tick;
    logic       paused;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    led_pattern_ctrl #(.TICK_COUNT(c_TICK)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .speed     (speed),
        .mode_load (mode_load),
        .pause     (pause),
        .step      (step),
        .dataOut   (dataOut),
        .tick      (tick),
        .paused    (paused)
    );

    always #5 clk = ~clk;

    // Advance one edge; sample and drive 1 time unit after it
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Cycles until the next tick pulse, -1 if none within the bound
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (tick !== 1'b1 && n < 100);
        if (tick !== 1'b1) n = -1;
    endtask

    // Pop queued values one per tick, checking value and spacing
    task automatic drain(input string name, input int gap);
        int n;
        logic [7:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_tick(n);
            total++;
            if (n !== gap) begin
                bad++;
                $display("FAIL %s gap: got %0d want %0d", name, n, gap);
            end
            total++;
            if (dataOut !== e) begin
                bad++;
                $display("FAIL %s data: got %h want %h", name, dataOut, e);
            end
        end
    endtask

    task automatic load(input logic [1:0] m, input logic [1:0] s);
        mode = m; speed = s; mode_load = 1'b1;
        cyc();
        mode_load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 2'b00; speed = 2'b00; mode_load = 1'b0;
        pause = 1'b0; step = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        total++;
        if (dataOut !== 8'h80 || tick !== 1'b0 || paused !== 1'b0) begin
            bad++;
            $display("FAIL reset: got d=%h t=%b p=%b want d=80 t=0 p=0", dataOut, tick, paused);
        end
    endtask

    task automatic test_rotate_right();
        logic [7:0] v = 8'h80;
        for (int i = 0; i < 8; i++) begin
            v = {v[0], v[7:1]};
            exp_q.push_back(v);
        end
        drain("rot_right", 8);
        total++;
        if (paused !== 1'b0) begin
            bad++;
            $display("FAIL rot_right paused: got %b want 0", paused);
        end
    endtask

    task automatic test_bounce();
        logic [7:0] seq [15] = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
                                 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40};
        load(2'b10, 2'd2);
        total++;
        if (dataOut !== 8'h80 || tick !== 1'b0) begin
            bad++;
            $display("FAIL bounce seed: got d=%h t=%b want d=80 t=0", dataOut, tick);
        end
        foreach (seq[i]) exp_q.push_back(seq[i]);
        drain("bounce", 2);
    endtask

    task automatic test_blink();
        load(2'b11, 2'd3);
        total++;
        if (dataOut !== 8'hFF || tick !== 1'b0) begin
            bad++;
            $display("FAIL blink seed: got d=%h t=%b want d=ff t=0", dataOut, tick);
        end
        for (int i = 0; i < 4; i++) exp_q.push_back((i % 2 == 0) ? 8'h00 : 8'hFF);
        drain("blink", 1);
    endtask

    task automatic test_pause_step();
        int n;
        logic [7:0] v;
        load(2'b00, 2'd0);
        // Step pulses in RUN are ignored
        step = 1'b1; cyc(); step = 1'b0;
        total++;
        if (tick !== 1'b0 || dataOut !== 8'h80) begin
            bad++;
            $display("FAIL step_in_run: got d=%h t=%b want d=80 t=0", dataOut, tick);
        end
        for (int i = 0; i < 6; i++) cyc();   // counter now at 7
        pause = 1'b1;
        cyc();
        total++;
        if (dataOut !== 8'h80 || tick !== 1'b0 || paused !== 1'b1) begin
            bad++;
            $display("FAIL pause_edge: got d=%h t=%b p=%b want d=80 t=0 p=1", dataOut, tick, paused);
        end
        exp_q.push_back(8'h40); exp_q.push_back(8'h20); exp_q.push_back(8'h10);
        for (int i = 0; i < 3; i++) begin
            cyc(); cyc();
            total++;
            if (tick !== 1'b0) begin
                bad++;
                $display("FAIL paused_idle tick: got %b want 0", tick);
            end
            step = 1'b1; cyc(); step = 1'b0;
            v = exp_q.pop_front();
            total++;
            if (tick !== 1'b1 || dataOut !== v || paused !== 1'b1) begin
                bad++;
                $display("FAIL step%0d: got d=%h t=%b p=%b want d=%h t=1 p=1", i, dataOut, tick, paused, v);
            end
        end
        pause = 1'b0;
        cyc();
        total++;
        if (paused !== 1'b0 || dataOut !== 8'h10 || tick !== 1'b0) begin
            bad++;
            $display("FAIL release: got d=%h t=%b p=%b want d=10 t=0 p=0", dataOut, tick, paused);
        end
        exp_q.push_back(8'h08);
        wait_tick(n);
        v = exp_q.pop_front();
        total++;
        if (n !== 8 || dataOut !== v) begin
            bad++;
            $display("FAIL after_release: got gap=%0d d=%h want gap=8 d=%h", n, dataOut, v);
        end
    endtask

    task automatic test_load_on_expiry();
        for (int i = 0; i < 7; i++) cyc();   // counter now at 7
        load(2'b01, 2'd0);
        total++;
        if (dataOut !== 8'h01 || tick !== 1'b0) begin
            bad++;
            $display("FAIL load_on_expiry: got d=%h t=%b want d=01 t=0", dataOut, tick);
        end
        exp_q.push_back(8'h02);
        drain("load_next", 8);
    endtask

    task automatic test_reset_mid();
        load(2'b10, 2'd3);
        for (int i = 0; i < 9; i++) cyc();   // 80 -> ... -> 01 -> 02 -> 04
        total++;
        if (dataOut !== 8'h04) begin
            bad++;
            $display("FAIL bounce_left: got %h want 04", dataOut);
        end
        rst = 1'b1; cyc(); rst = 1'b0;
        total++;
        if (dataOut !== 8'h80 || paused !== 1'b0 || tick !== 1'b0) begin
            bad++;
            $display("FAIL reset_bounce: got d=%h t=%b p=%b want d=80 t=0 p=0", dataOut, tick, paused);
        end
        exp_q.push_back(8'h40);
        drain("after_reset_bounce", 8);
        pause = 1'b1; cyc();
        total++;
        if (paused !== 1'b1) begin
            bad++;
            $display("FAIL pause_before_reset: got %b want 1", paused);
        end
        rst = 1'b1; pause = 1'b0; cyc(); rst = 1'b0;
        total++;
        if (dataOut !== 8'h80 || paused !== 1'b0) begin
            bad++;
            $display("FAIL reset_paused: got d=%h p=%b want d=80 p=0", dataOut, paused);
        end
        exp_q.push_back(8'h40); exp_q.push_back(8'h20);
        drain("after_reset_pause", 8);
    endtask

    initial begin
        test_reset();
        test_rotate_right();
        test_bounce();
        test_blink();
        test_pause_step();
        test_load_on_expiry();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
